// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle ARM control unit
package arm_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_UNKNOWN  = 4'd10;

    typedef enum logic [3:0] {
        FETCH    = S_FETCH,
        DECODE   = S_DECODE,
        MEMADR   = S_MEMADR,
        MEMRD    = S_MEMRD,
        MEMWB    = S_MEMWB,
        MEMWR    = S_MEMWR,
        EXECUTER = S_EXECUTER,
        EXECUTEI = S_EXECUTEI,
        ALUWB    = S_ALUWB,
        BRANCH   = S_BRANCH,
        UNKNOWN  = S_UNKNOWN
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] SRCB_WD  = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALUR   = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - Moore main controller sequencing fetch/decode/execute/memory/writeback
module mainfsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch
);

    state_t state, next;

    // only the I and L/S bits steer the sequence; the rest belongs to the ALU decoder
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  next = MEMADR;
                    OP_DP:   next = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   next = BRANCH;
                    default: next = UNKNOWN;
                endcase
            end
            MEMADR:   next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    // write strobes appear only after the execute/address cycle so CondEx is already registered
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_WD;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALUR;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALUR;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMRD:    AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALUR;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
